// File: rtl/csr_rmw_ctrl_pkg.sv
// CSR read-modify-write controller shared types: funct3 op encodings, FSM states, trap CSR indices.
// Combinational helpers only; no state lives here.
package csr_pkg;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_READ       = 3'd1,
        ST_WRITE      = 3'd2,
        ST_TRAP_EPC   = 3'd3,
        ST_TRAP_CAUSE = 3'd4
    } csr_state_e;

    localparam logic [5:0] CSR_MEPC_IDX   = 6'h01;
    localparam logic [5:0] CSR_MCAUSE_IDX = 6'h02;

    // funct3 000 and 100 are the only illegal encodings
    function automatic logic op_legal(input logic [2:0] op);
        return op[1:0] != 2'b00;
    endfunction

    // Plain writes always commit; set/clear commit only with a non-zero source
    function automatic logic op_always_writes(input logic [2:0] op);
        return op[1:0] == 2'b01;
    endfunction

endpackage

// File: rtl/csr_rmw_ctrl_if.sv
// Request/response/trap handshakes plus the CSR file read/write port of the RMW controller.
// slave = controller side, master = pipeline and CSR file side.
interface csr_rmw_ctrl_if;
    logic        inst_valid;
    logic        inst_ready;
    logic [2:0]  inst_op;
    logic [5:0]  inst_addr;
    logic [31:0] inst_src;
    logic        inst_src_zero;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic        trap_valid;
    logic        trap_ready;
    logic [31:0] trap_epc;
    logic [31:0] trap_cause;
    logic        csr_writeEn;
    logic [5:0]  csr_waddr;
    logic [31:0] csr_wdata;
    logic [5:0]  csr_raddr;
    logic [31:0] csr_rdata;

    modport slave (
        input  inst_valid, inst_op, inst_addr, inst_src, inst_src_zero,
        input  trap_valid, trap_epc, trap_cause, csr_rdata,
        output inst_ready, resp_valid, resp_rdata, resp_illegal, trap_ready,
        output csr_writeEn, csr_waddr, csr_wdata, csr_raddr
    );

    modport master (
        output inst_valid, inst_op, inst_addr, inst_src, inst_src_zero,
        output trap_valid, trap_epc, trap_cause, csr_rdata,
        input  inst_ready, resp_valid, resp_rdata, resp_illegal, trap_ready,
        input  csr_writeEn, csr_waddr, csr_wdata, csr_raddr
    );
endinterface

// File: rtl/csr_rmw_ctrl_alu.sv
// Combinational CSR modify: write, set-bits or clear-bits of the old value; zero latency.
// Illegal encodings pass the old value through unchanged.
module csr_alu
    import csr_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] old_i,
    input  logic [31:0] src_i,
    output logic [31:0] new_o
);

    always_comb begin
        new_o = old_i;
        case (op_i)
            CSR_RW, CSR_RWI: new_o = src_i;
            CSR_RS, CSR_RSI: new_o = old_i | src_i;
            CSR_RC, CSR_RCI: new_o = old_i & ~src_i;
            default:         new_o = old_i;
        endcase
    end

endmodule

// File: rtl/csr_rmw_ctrl.sv
// CSR RMW controller: instruction response 2 cycles after accept, trap writes mepc then mcause.
// Ready only in IDLE (trap wins ties); one request in flight, issue interval 3 cycles.
module csr_rmw_ctrl
    import csr_pkg::*;
#(
    parameter logic [5:0] MEPC_ADDR   = CSR_MEPC_IDX,
    parameter logic [5:0] MCAUSE_ADDR = CSR_MCAUSE_IDX
) (
    input  logic           clk,
    input  logic           reset,
    csr_rmw_ctrl_if.slave  bus
);

    csr_state_e  state_q, state_d;
    logic [2:0]  op_q;
    logic [5:0]  addr_q;
    logic [31:0] src_q;
    logic        src_zero_q;
    logic [31:0] epc_q, cause_q, old_q;
    logic [5:0]  raddr_q, raddr_d, waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0] alu_new;
    logic        idle, inst_rdy, trap_rdy, inst_acc, trap_acc, we;

    csr_alu u_alu (
        .op_i  (op_q),
        .old_i (old_q),
        .src_i (src_q),
        .new_o (alu_new)
    );

    // Ready is gated by reset itself so it drops the moment reset asserts
    assign idle     = (state_q == ST_IDLE);
    assign trap_rdy = idle && reset;
    assign inst_rdy = idle && reset && !bus.trap_valid;
    assign trap_acc = bus.trap_valid && trap_rdy;
    assign inst_acc = bus.inst_valid && inst_rdy;

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trap_acc)      state_d = ST_TRAP_EPC;
                else if (inst_acc) state_d = ST_READ;
            end
            ST_READ: begin
                raddr_d = addr_q;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                waddr_d = addr_q;
                wdata_d = alu_new;
                rdata_d = old_q;
                we      = op_legal(op_q) && (op_always_writes(op_q) || !src_zero_q);
                state_d = ST_IDLE;
            end
            ST_TRAP_EPC: begin
                waddr_d = MEPC_ADDR;
                wdata_d = epc_q;
                we      = 1'b1;
                state_d = ST_TRAP_CAUSE;
            end
            ST_TRAP_CAUSE: begin
                waddr_d = MCAUSE_ADDR;
                wdata_d = cause_q;
                we      = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            epc_q      <= '0;
            cause_q    <= '0;
            old_q      <= '0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            if (trap_acc) begin
                epc_q   <= bus.trap_epc;
                cause_q <= bus.trap_cause;
            end
            if (inst_acc) begin
                op_q       <= bus.inst_op;
                addr_q     <= bus.inst_addr;
                src_q      <= bus.inst_src;
                src_zero_q <= bus.inst_src_zero;
            end
            if (state_q == ST_READ) old_q <= bus.csr_rdata;
        end
    end

    assign bus.inst_ready   = inst_rdy;
    assign bus.trap_ready   = trap_rdy;
    assign bus.resp_valid   = (state_q == ST_WRITE);
    assign bus.resp_illegal = (state_q == ST_WRITE) && !op_legal(op_q);
    assign bus.resp_rdata   = rdata_d;
    assign bus.csr_writeEn  = we;
    assign bus.csr_waddr    = waddr_d;
    assign bus.csr_wdata    = wdata_d;
    assign bus.csr_raddr    = raddr_d;

endmodule
